// File: rtl/ecc_secded_monitor.sv
// Parametrised SECDED check/correct pipeline with fault injection, saturating
// CE/UE counters and a small error-record FIFO that software drains.
package ecc_secded_pkg;

    function automatic int calc_p(input int data_w);
        int p;
        p = 1;
        while ((1 << p) < data_w + p + 1) p++;
        return p;
    endfunction

    // Hamming position of data bit k: the k-th non-power-of-two position from 3 up.
    function automatic int data_pos(input int k);
        int pos;
        int idx;
        pos = 2;
        idx = -1;
        while (idx < k) begin
            pos++;
            if ((pos & (pos - 1)) != 0) idx++;
        end
        return pos;
    endfunction

endpackage

module ecc_secded_monitor #(
    parameter int DATA_W    = 64,
    parameter int ADDR_W    = 14,
    parameter int LOG_DEPTH = 4,
    parameter int CNT_W     = 16,
    // Derived from DATA_W; not meant to be overridden.
    parameter int CHK_W     = ecc_secded_pkg::calc_p(DATA_W) + 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    input  logic [ADDR_W-1:0]       in_addr,
    input  logic [DATA_W-1:0]       in_data,
    input  logic [CHK_W-1:0]        in_chk,
    input  logic                    inj_en,
    input  logic [DATA_W+CHK_W-1:0] inj_mask,
    output logic                    out_valid,
    output logic [DATA_W-1:0]       out_data,
    output logic                    out_ce,
    output logic                    out_ue,
    output logic [CNT_W-1:0]        ce_cnt,
    output logic [CNT_W-1:0]        ue_cnt,
    output logic                    err_sticky,
    output logic                    log_valid,
    input  logic                    log_rd,
    output logic                    log_type,
    output logic [ADDR_W-1:0]       log_addr,
    output logic [CHK_W-1:0]        log_syn,
    output logic                    log_ovf,
    input  logic                    clr
);

    localparam int               P        = CHK_W - 1;
    localparam int               IDX_W    = $clog2(LOG_DEPTH);
    localparam int               ADDR_LOG = IDX_W + 1;
    localparam logic [P-1:0]     MAX_POS  = P'(DATA_W + P);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    typedef struct packed {
        logic              typ;
        logic [ADDR_W-1:0] addr;
        logic [CHK_W-1:0]  syn;
    } log_rec_t;

    logic [P-1:0] pos_tab [DATA_W];

    for (genvar k = 0; k < DATA_W; k++) begin : g_pos
        localparam int POS = ecc_secded_pkg::data_pos(k);
        assign pos_tab[k] = POS[P-1:0];
    end

    // Stage 1: inject, then fold the position of every set bit into the syndrome.
    logic [DATA_W+CHK_W-1:0] w;
    logic [P-1:0]            syn_c;
    logic                    pe_c;

    // NOTE: combinational blocks use blocking '=' so each loop step sees the previous one.
    always_comb begin
        w     = {in_chk, in_data} ^ (inj_en ? inj_mask : '0);
        syn_c = w[DATA_W +: P];
        for (int k = 0; k < DATA_W; k++) begin
            if (w[k]) syn_c = syn_c ^ pos_tab[k];
        end
    end

    assign pe_c = ^w;

    logic              v1;
    logic              pe1;
    logic [P-1:0]      s1;
    logic [DATA_W-1:0] d1;
    logic [ADDR_W-1:0] a1;

    // NOTE: clocked state uses non-blocking '<=' so all registers update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1  <= 1'b0;
            pe1 <= 1'b0;
            s1  <= '0;
            d1  <= '0;
            a1  <= '0;
        end else begin
            v1 <= in_valid;
            if (in_valid) begin
                pe1 <= pe_c;
                s1  <= syn_c;
                d1  <= w[DATA_W-1:0];
                a1  <= in_addr;
            end
        end
    end

    // Stage 2: classify and correct.
    logic              ce_c;
    logic              ue_c;
    logic [DATA_W-1:0] flip;

    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        flip = '0;
        ce_c = pe1 && (s1 <= MAX_POS);
        ue_c = (!pe1 && (s1 != '0)) || (pe1 && (s1 > MAX_POS));
        for (int k = 0; k < DATA_W; k++) begin
            flip[k] = ce_c && (pos_tab[k] == s1);
        end
    end

    logic [ADDR_W-1:0] rec_addr;
    logic [CHK_W-1:0]  rec_syn;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ce    <= 1'b0;
            out_ue    <= 1'b0;
            rec_addr  <= '0;
            rec_syn   <= '0;
        end else begin
            out_valid <= v1;
            out_ce    <= v1 && ce_c;
            out_ue    <= v1 && ue_c;
            if (v1) begin
                out_data <= d1 ^ flip;
                rec_addr <= a1;
                rec_syn  <= {pe1, s1};
            end
        end
    end

    // Event bookkeeping: clr loses to a coincident event.
    logic ce_ev;
    logic ue_ev;
    logic push;
    logic pop;
    logic empty;
    logic full;
    logic do_push;

    assign ce_ev = out_valid && out_ce;
    assign ue_ev = out_valid && out_ue;
    assign push  = ce_ev || ue_ev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ce_cnt     <= '0;
            ue_cnt     <= '0;
            err_sticky <= 1'b0;
            log_ovf    <= 1'b0;
        end else if (clr) begin
            ce_cnt     <= CNT_W'(ce_ev);
            ue_cnt     <= CNT_W'(ue_ev);
            err_sticky <= push;
            log_ovf    <= 1'b0;
        end else begin
            if (ce_ev && (ce_cnt != CNT_MAX)) ce_cnt <= ce_cnt + CNT_W'(1);
            if (ue_ev && (ue_cnt != CNT_MAX)) ue_cnt <= ue_cnt + CNT_W'(1);
            if (push) err_sticky <= 1'b1;
            if (push && full && !pop) log_ovf <= 1'b1;
        end
    end

    // Log FIFO: one extra pointer bit tells full from empty.
    log_rec_t            mem [LOG_DEPTH];
    log_rec_t            rec;
    log_rec_t            head;
    logic [ADDR_LOG-1:0] wp;
    logic [ADDR_LOG-1:0] rp;

    assign empty   = (wp == rp);
    assign full    = (wp[IDX_W] != rp[IDX_W]) && (wp[IDX_W-1:0] == rp[IDX_W-1:0]);
    assign pop     = log_rd && !empty;
    assign do_push = push && (!full || pop);

    assign rec.typ  = out_ue;
    assign rec.addr = rec_addr;
    assign rec.syn  = rec_syn;

    // NOTE: the log storage is reset because the head record is visible on the ports.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wp <= '0;
            rp <= '0;
            for (int i = 0; i < LOG_DEPTH; i++) mem[i] <= '0;
        end else begin
            if (do_push) begin
                mem[wp[IDX_W-1:0]] <= rec;
                wp                 <= wp + ADDR_LOG'(1);
            end
            if (pop) rp <= rp + ADDR_LOG'(1);
        end
    end

    assign head      = mem[rp[IDX_W-1:0]];
    assign log_valid = !empty;
    assign log_type  = head.typ;
    assign log_addr  = head.addr;
    assign log_syn   = head.syn;

endmodule

// File: tb/tb_ecc_secded_monitor.sv
// Self-checking bench for ecc_secded_monitor: the reference model derives results
// from the injected error pattern (which codeword positions flipped), not from the syndrome logic.
module tb_ecc_secded_monitor;

    localparam int DW    = 64;
    localparam int AW    = 14;
    localparam int DEPTH = 4;
    localparam int P     = 7;
    localparam int CW    = P + 1;
    localparam int NB    = DW + CW;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n;
    logic          in_valid;
    logic [AW-1:0] in_addr;
    logic [DW-1:0] in_data;
    logic [CW-1:0] in_chk;
    logic          inj_en;
    logic [NB-1:0] inj_mask;
    logic          log_rd;
    logic          clr;

    logic          out_valid, out_ce, out_ue, err_sticky, log_valid, log_type, log_ovf;
    logic [DW-1:0] out_data;
    logic [15:0]   ce_cnt, ue_cnt;
    logic [AW-1:0] log_addr;
    logic [CW-1:0] log_syn;

    logic          out_valid_s, out_ce_s, out_ue_s, err_sticky_s, log_valid_s, log_type_s, log_ovf_s;
    logic [DW-1:0] out_data_s;
    logic [3:0]    ce_cnt_s, ue_cnt_s;
    logic [AW-1:0] log_addr_s;
    logic [CW-1:0] log_syn_s;

    ecc_secded_monitor #(.DATA_W(DW), .ADDR_W(AW), .LOG_DEPTH(DEPTH), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_addr(in_addr), .in_data(in_data),
        .in_chk(in_chk), .inj_en(inj_en), .inj_mask(inj_mask), .out_valid(out_valid),
        .out_data(out_data), .out_ce(out_ce), .out_ue(out_ue), .ce_cnt(ce_cnt), .ue_cnt(ue_cnt),
        .err_sticky(err_sticky), .log_valid(log_valid), .log_rd(log_rd), .log_type(log_type),
        .log_addr(log_addr), .log_syn(log_syn), .log_ovf(log_ovf), .clr(clr)
    );

    ecc_secded_monitor #(.DATA_W(DW), .ADDR_W(AW), .LOG_DEPTH(DEPTH), .CNT_W(4)) dut_small (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_addr(in_addr), .in_data(in_data),
        .in_chk(in_chk), .inj_en(inj_en), .inj_mask(inj_mask), .out_valid(out_valid_s),
        .out_data(out_data_s), .out_ce(out_ce_s), .out_ue(out_ue_s), .ce_cnt(ce_cnt_s),
        .ue_cnt(ue_cnt_s), .err_sticky(err_sticky_s), .log_valid(log_valid_s), .log_rd(log_rd),
        .log_type(log_type_s), .log_addr(log_addr_s), .log_syn(log_syn_s), .log_ovf(log_ovf_s),
        .clr(clr)
    );

    typedef struct {
        logic [DW-1:0] data;
        logic [AW-1:0] addr;
        logic          inj;
        logic [NB-1:0] mask;
        bit            clr_ev;
        bit            pop_ev;
    } stim_t;

    typedef struct {
        logic          typ;
        logic [AW-1:0] addr;
        logic [CW-1:0] syn;
    } rec_t;

    stim_t stim_q[$];
    rec_t  log_q[$];
    int    pos_of[DW];
    int    checks;
    int    errors;
    int    m_ce, m_ue, m_ce4, m_ue4;
    bit    m_sticky, m_ovf;

    // Position in the Hamming codeword of inj_mask bit j (0 = overall parity bit).
    function automatic int cw_pos(input int j);
        if (j < DW) return pos_of[j];
        if (j < DW + P) return 1 << (j - DW);
        return 0;
    endfunction

    function automatic logic [CW-1:0] encode(input logic [DW-1:0] d);
        logic [CW-1:0] c;
        c = '0;
        for (int k = 0; k < DW; k++) begin
            if (d[k]) begin
                for (int i = 0; i < P; i++) begin
                    if (pos_of[k][i]) c[i] = ~c[i];
                end
            end
        end
        c[P] = ^{d, c[P-1:0]};
        return c;
    endfunction

    function automatic logic [NB-1:0] rand_mask(input int nbits);
        logic [NB-1:0] m;
        m = '0;
        while ($countones(m) < nbits) m[$urandom_range(NB - 1, 0)] = 1'b1;
        return m;
    endfunction

    // Expected result from the error pattern: count flips, XOR their positions.
    function automatic void model_decode(input stim_t s, output logic [DW-1:0] d,
                                         output logic ce, output logic ue, output logic [CW-1:0] syn);
        logic [NB-1:0] em;
        int            x;
        int            n;
        logic          pe;
        em = s.inj ? s.mask : '0;
        x  = 0;
        n  = 0;
        for (int j = 0; j < NB; j++) begin
            if (em[j]) begin
                n++;
                x = x ^ cw_pos(j);
            end
        end
        pe = n[0];
        d  = s.data ^ em[DW-1:0];
        ce = pe && (x <= DW + P);
        ue = (!pe && x != 0) || (pe && x > DW + P);
        if (ce) begin
            for (int k = 0; k < DW; k++) begin
                if (pos_of[k] == x) d[k] = ~d[k];
            end
        end
        syn[P]     = pe;
        syn[P-1:0] = x[P-1:0];
    endfunction

    function automatic void model_edge(input stim_t s);
        logic [DW-1:0] d;
        logic          ce, ue;
        logic [CW-1:0] syn;
        rec_t          r;
        model_decode(s, d, ce, ue, syn);
        if (s.pop_ev && log_q.size() > 0) void'(log_q.pop_front());
        if (ce || ue) begin
            r.typ  = ue;
            r.addr = s.addr;
            r.syn  = syn;
            if (log_q.size() < DEPTH) log_q.push_back(r);
            else m_ovf = 1'b1;
        end
        if (s.clr_ev) begin
            m_ce = int'(ce); m_ue = int'(ue); m_ce4 = int'(ce); m_ue4 = int'(ue);
            m_sticky = ce || ue;
            m_ovf    = 1'b0;
        end else begin
            if (ce && m_ce < 65535) m_ce++;
            if (ue && m_ue < 65535) m_ue++;
            if (ce && m_ce4 < 15) m_ce4++;
            if (ue && m_ue4 < 15) m_ue4++;
            if (ce || ue) m_sticky = 1'b1;
        end
    endfunction

    function automatic void add_word(input logic [DW-1:0] d, input logic [NB-1:0] mask,
                                     input logic inj, input bit clr_ev = 0, input bit pop_ev = 0);
        stim_t s;
        s.data   = d;
        s.addr   = AW'($urandom);
        s.inj    = inj;
        s.mask   = mask;
        s.clr_ev = clr_ev;
        s.pop_ev = pop_ev;
        stim_q.push_back(s);
    endfunction

    task automatic drive_word(input stim_t s);
        in_valid = 1'b1;
        in_addr  = s.addr;
        in_data  = s.data;
        in_chk   = encode(s.data);
        inj_en   = s.inj;
        inj_mask = s.mask;
    endtask

    task automatic idle_inputs();
        in_valid = 1'b0;
        inj_en   = 1'b0;
        in_addr  = '0;
        in_data  = '0;
        in_chk   = '0;
        inj_mask = '0;
    endtask

    task automatic model_reset();
        m_ce = 0; m_ue = 0; m_ce4 = 0; m_ue4 = 0;
        m_sticky = 1'b0;
        m_ovf    = 1'b0;
        log_q.delete();
    endtask

    task automatic apply_reset();
        rst_n  = 1'b0;
        clr    = 1'b0;
        log_rd = 1'b0;
        idle_inputs();
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic do_clr();
        @(posedge clk); #1;
        clr = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0;
        m_ce = 0; m_ue = 0; m_ce4 = 0; m_ue4 = 0;
        m_sticky = 1'b0;
        m_ovf    = 1'b0;
    endtask

    // Streams stim_q back-to-back; word i must appear exactly two cycles after it is driven.
    task automatic run_stream();
        int            n;
        logic [DW-1:0] ed;
        logic          ece, eue;
        logic [CW-1:0] esyn;
        n = stim_q.size();
        for (int j = 0; j < n + 2; j++) begin
            @(posedge clk); #1;
            if (j < n) drive_word(stim_q[j]);
            else idle_inputs();
            clr    = 1'b0;
            log_rd = 1'b0;
            if (j >= 2) begin
                clr    = stim_q[j-2].clr_ev;
                log_rd = stim_q[j-2].pop_ev;
            end
            @(negedge clk);
            checks++;
            if (j >= 2) begin
                model_decode(stim_q[j-2], ed, ece, eue, esyn);
                if (out_valid !== 1'b1 || out_data !== ed || out_ce !== ece || out_ue !== eue) begin
                    errors++;
                    $display("FAIL stream word %0d: got valid=%b data=%h ce=%b ue=%b, expected valid=1 data=%h ce=%b ue=%b",
                             j - 2, out_valid, out_data, out_ce, out_ue, ed, ece, eue);
                end
                model_edge(stim_q[j-2]);
            end else if (out_valid !== 1'b0) begin
                errors++;
                $display("FAIL early out_valid at cycle %0d: got %b, expected 0", j, out_valid);
            end
        end
        @(posedge clk); #1;
        clr    = 1'b0;
        log_rd = 1'b0;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL trailing out_valid: got %b, expected 0", out_valid);
        end
        checks++;
        if (ce_cnt !== 16'(m_ce) || ue_cnt !== 16'(m_ue)) begin
            errors++;
            $display("FAIL counters: got ce=%0d ue=%0d, expected ce=%0d ue=%0d", ce_cnt, ue_cnt, m_ce, m_ue);
        end
        checks++;
        if (ce_cnt_s !== 4'(m_ce4) || ue_cnt_s !== 4'(m_ue4)) begin
            errors++;
            $display("FAIL small counters: got ce=%0d ue=%0d, expected ce=%0d ue=%0d", ce_cnt_s, ue_cnt_s, m_ce4, m_ue4);
        end
        checks++;
        if (err_sticky !== m_sticky || log_ovf !== m_ovf || log_valid !== (log_q.size() > 0)) begin
            errors++;
            $display("FAIL flags: got sticky=%b ovf=%b log_valid=%b, expected sticky=%b ovf=%b log_valid=%b",
                     err_sticky, log_ovf, log_valid, m_sticky, m_ovf, log_q.size() > 0);
        end
        stim_q.delete();
    endtask

    task automatic drain_log();
        for (int i = 0; i <= DEPTH; i++) begin
            @(negedge clk);
            checks++;
            if (log_valid !== (log_q.size() > 0)) begin
                errors++;
                $display("FAIL log_valid while draining: got %b, expected %b", log_valid, log_q.size() > 0);
            end
            if (log_q.size() == 0) break;
            checks++;
            if (log_type !== log_q[0].typ || log_addr !== log_q[0].addr || log_syn !== log_q[0].syn) begin
                errors++;
                $display("FAIL log head: got type=%b addr=%h syn=%h, expected type=%b addr=%h syn=%h",
                         log_type, log_addr, log_syn, log_q[0].typ, log_q[0].addr, log_q[0].syn);
            end
            log_rd = 1'b1;
            @(posedge clk); #1;
            log_rd = 1'b0;
            void'(log_q.pop_front());
        end
    endtask

    task automatic test_reset();
        apply_reset();
        @(negedge clk);
        checks++;
        if ({out_valid, out_ce, out_ue, err_sticky, log_valid, log_ovf} !== 6'b0) begin
            errors++;
            $display("FAIL reset flags: got %b, expected 000000",
                     {out_valid, out_ce, out_ue, err_sticky, log_valid, log_ovf});
        end
        checks++;
        if (ce_cnt !== 16'h0 || ue_cnt !== 16'h0 || out_data !== '0) begin
            errors++;
            $display("FAIL reset values: got ce=%0d ue=%0d data=%h, expected all zero", ce_cnt, ue_cnt, out_data);
        end
        checks++;
        if ({log_type, log_addr, log_syn} !== '0) begin
            errors++;
            $display("FAIL reset log head: got %h, expected 0", {log_type, log_addr, log_syn});
        end
    endtask

    task automatic test_clean();
        add_word(64'h0123_4567_89AB_CDEF, '0, 1'b0);
        run_stream();
    endtask

    task automatic test_ce_data();
        logic [NB-1:0] m;
        m    = '0;
        m[5] = 1'b1;
        add_word(64'h0123_4567_89AB_CDEF, m, 1'b1);
        run_stream();
        checks++;
        if (ce_cnt !== 16'd1 || log_type !== 1'b0 || log_syn !== 8'h8A) begin
            errors++;
            $display("FAIL ce data bit5: got ce_cnt=%0d type=%b syn=%h, expected 1 0 8a", ce_cnt, log_type, log_syn);
        end
        drain_log();
    endtask

    task automatic test_ce_chk_ue();
        logic [NB-1:0] m;
        m = '0; m[DW] = 1'b1;
        add_word({$urandom, $urandom}, m, 1'b1);
        m = '0; m[0] = 1'b1; m[1] = 1'b1;
        add_word({$urandom, $urandom}, m, 1'b1);
        m = '0; m[DW+6] = 1'b1; m[DW+3] = 1'b1; m[3] = 1'b1;
        add_word({$urandom, $urandom}, m, 1'b1);
        run_stream();
        checks++;
        if (log_type !== 1'b0 || log_syn !== 8'h81) begin
            errors++;
            $display("FAIL ce on chk0: got type=%b syn=%h, expected 0 81", log_type, log_syn);
        end
        drain_log();
    endtask

    task automatic test_overflow();
        for (int i = 0; i < DEPTH + 2; i++) add_word({$urandom, $urandom}, rand_mask(1), 1'b1);
        run_stream();
        checks++;
        if (log_ovf !== 1'b1) begin
            errors++;
            $display("FAIL overflow flag: got %b, expected 1", log_ovf);
        end
        add_word({$urandom, $urandom}, rand_mask(1), 1'b1, 1'b1, 1'b0);
        run_stream();
        checks++;
        if (ce_cnt !== 16'd1 || log_ovf !== 1'b0 || err_sticky !== 1'b1) begin
            errors++;
            $display("FAIL clr with event: got ce=%0d ovf=%b sticky=%b, expected 1 0 1", ce_cnt, log_ovf, err_sticky);
        end
        drain_log();
    endtask

    task automatic test_full_push_pop();
        for (int i = 0; i < DEPTH; i++) add_word({$urandom, $urandom}, rand_mask(2), 1'b1);
        add_word({$urandom, $urandom}, rand_mask(1), 1'b1, 1'b0, 1'b1);
        run_stream();
        checks++;
        if (log_ovf !== 1'b0) begin
            errors++;
            $display("FAIL push+pop when full: got ovf=%b, expected 0", log_ovf);
        end
        drain_log();
    endtask

    task automatic test_saturation();
        do_clr();
        for (int i = 0; i < 17; i++) add_word({$urandom, $urandom}, rand_mask(1), 1'b1);
        run_stream();
        checks++;
        if (ce_cnt_s !== 4'hF || ce_cnt !== 16'd17) begin
            errors++;
            $display("FAIL saturation: got small=%h wide=%0d, expected f 17", ce_cnt_s, ce_cnt);
        end
        drain_log();
    endtask

    task automatic test_log_empty_read();
        @(posedge clk); #1;
        log_rd = 1'b1;
        @(posedge clk); #1;
        log_rd = 1'b0;
        @(negedge clk);
        checks++;
        if (log_valid !== 1'b0) begin
            errors++;
            $display("FAIL pop while empty: got log_valid=%b, expected 0", log_valid);
        end
        add_word({$urandom, $urandom}, rand_mask(2), 1'b1);
        run_stream();
        drain_log();
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 150; i++) begin
            case ($urandom_range(3, 0))
                0:       add_word({$urandom, $urandom}, rand_mask(2), 1'b0);
                1:       add_word({$urandom, $urandom}, '0, 1'b1);
                2:       add_word({$urandom, $urandom}, rand_mask(1), 1'b1);
                default: add_word({$urandom, $urandom}, rand_mask(2), 1'b1);
            endcase
        end
        run_stream();
        drain_log();
    endtask

    task automatic test_midreset();
        for (int i = 0; i < 2; i++) add_word({$urandom, $urandom}, rand_mask(1), 1'b1);
        @(posedge clk); #1;
        drive_word(stim_q[0]);
        @(posedge clk); #1;
        drive_word(stim_q[1]);
        #2;
        rst_n = 1'b0;
        idle_inputs();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        stim_q.delete();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b0) begin
                errors++;
                $display("FAIL out_valid after mid reset, cycle %0d: got %b, expected 0", i, out_valid);
            end
        end
        checks++;
        if (ce_cnt !== 16'h0 || ue_cnt !== 16'h0 || log_valid !== 1'b0 || err_sticky !== 1'b0) begin
            errors++;
            $display("FAIL state after mid reset: got ce=%0d ue=%0d log_valid=%b sticky=%b, expected 0 0 0 0",
                     ce_cnt, ue_cnt, log_valid, err_sticky);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        for (int k = 0; k < DW; k++) begin
            int pos;
            int idx;
            pos = (k == 0) ? 2 : pos_of[k-1];
            idx = 0;
            while (idx == 0) begin
                pos++;
                if ((pos & (pos - 1)) != 0) idx = 1;
            end
            pos_of[k] = pos;
        end
        test_reset();
        test_clean();
        test_ce_data();
        test_ce_chk_ue();
        test_overflow();
        test_full_push_pop();
        test_saturation();
        test_log_empty_read();
        test_back_to_back();
        test_midreset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
